// File: rtl/rx_ctrl_sched.sv
// Rx control/scheduling block: staged Rx configuration committed only while the
// Rx engine is idle, plus a small receive FIFO with per-byte error flags and host flags.
module rx_ctrl_sched #(
  parameter int          DEPTH     = 4,
  parameter int          AW        = 2,
  parameter logic [18:0] DEFAULT_K = 19'd10416
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [21:0] cfg_wdata,
  input  logic        rx_busy,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_perr,
  input  logic        rx_ferr,
  input  logic        reads,
  output logic [18:0] k,
  output logic        eight,
  output logic        p_en,
  output logic        even,
  output logic        cfg_pend,
  output logic [7:0]  data_out,
  output logic        parity_err,
  output logic        frame_err,
  output logic        rx_rdy,
  output logic        overflow,
  output logic        irq
);

  typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_e;

  cfg_state_e  state_q, state_d;
  logic [21:0] stage_q, stage_d;
  logic [18:0] k_q, k_d;
  logic        eight_q, eight_d;
  logic        p_en_q, p_en_d;
  logic        even_q, even_d;

  logic [9:0]  mem_q [DEPTH];
  logic [9:0]  mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        irq_q, irq_d;

  logic        empty, full, pop, push, drop;
  logic [9:0]  head, entry;

  // A new write always beats a commit, so the last staged word is what lands.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    eight_d = eight_q;
    p_en_d  = p_en_q;
    even_d  = even_q;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_we) begin
          stage_d = cfg_wdata;
          state_d = CFG_PEND;
        end
      end
      CFG_PEND: begin
        if (cfg_we) begin
          stage_d = cfg_wdata;
        end else if (!rx_busy) begin
          k_d     = stage_q[18:0];
          eight_d = stage_q[19];
          p_en_d  = stage_q[20];
          even_d  = stage_q[21];
          state_d = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = reads && !empty;
  assign push  = rx_done && (!full || pop);
  assign drop  = rx_done && full && !pop;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign entry = {rx_ferr, rx_perr, rx_data[7] & eight_q, rx_data[6:0]};

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = entry;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    // A drop in the same cycle as a read leaves the sticky flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (reads) begin
      overflow_d = 1'b0;
    end
    irq_d = rx_rdy | overflow_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CFG_IDLE;
      stage_q    <= '0;
      k_q        <= DEFAULT_K;
      eight_q    <= 1'b1;
      p_en_q     <= 1'b0;
      even_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      k_q        <= k_d;
      eight_q    <= eight_d;
      p_en_q     <= p_en_d;
      even_q     <= even_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  assign k          = k_q;
  assign eight      = eight_q;
  assign p_en       = p_en_q;
  assign even       = even_q;
  assign cfg_pend   = (state_q == CFG_PEND);
  assign data_out   = empty ? 8'h00 : head[7:0];
  assign parity_err = empty ? 1'b0 : head[8];
  assign frame_err  = empty ? 1'b0 : head[9];
  assign rx_rdy     = !empty;
  assign overflow   = overflow_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_rx_ctrl_sched.sv
// Directed bench for rx_ctrl_sched: config staging/commit, FIFO ordering,
// overflow, full-with-pop wrap, and asynchronous reset mid-stream.
module tb_rx_ctrl_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [21:0] cfg_wdata;
  logic        rx_busy;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        rx_perr;
  logic        rx_ferr;
  logic        reads;
  logic [18:0] k;
  logic        eight, p_en, even, cfg_pend;
  logic [7:0]  data_out;
  logic        parity_err, frame_err, rx_rdy, overflow, irq;

  int n_checks = 0;
  int n_fail   = 0;

  rx_ctrl_sched #(.DEPTH(4), .AW(2), .DEFAULT_K(19'd10416)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .rx_busy(rx_busy), .rx_done(rx_done), .rx_data(rx_data),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .reads(reads),
    .k(k), .eight(eight), .p_en(p_en), .even(even), .cfg_pend(cfg_pend),
    .data_out(data_out), .parity_err(parity_err), .frame_err(frame_err),
    .rx_rdy(rx_rdy), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    rx_done = 1'b1; rx_data = d; rx_perr = pe; rx_ferr = fe;
    tick();
    rx_done = 1'b0; rx_perr = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic pop();
    reads = 1'b1;
    tick();
    reads = 1'b0;
  endtask

  function automatic logic [21:0] cfg(input logic ev, input logic pe, input logic e8, input logic [18:0] kk);
    return {ev, pe, e8, kk};
  endfunction

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_wdata = '0; rx_busy = 1'b0;
    rx_done = 1'b0; rx_data = '0; rx_perr = 1'b0; rx_ferr = 1'b0; reads = 1'b0;

    // Reset values
    #12;
    check("rst_k", k, 19'd10416);
    check("rst_eight", eight, 1);
    check("rst_rdy", rx_rdy, 0);
    #5 rst = 1'b1;
    repeat (3) tick();
    check("idle_k", k, 19'd10416);
    check("idle_eight", eight, 1);
    check("idle_pen", p_en, 0);
    check("idle_even", even, 0);
    check("idle_rdy", rx_rdy, 0);
    check("idle_irq", irq, 0);
    check("idle_pend", cfg_pend, 0);
    check("idle_data", data_out, 0);

    // Config writes held off while busy, last write wins
    rx_busy = 1'b1;
    cfg_we = 1'b1; cfg_wdata = cfg(1'b0, 1'b1, 1'b1, 19'd5208);
    tick();
    cfg_we = 1'b0;
    check("busy_pend1", cfg_pend, 1);
    check("busy_k1", k, 19'd10416);
    repeat (19) tick();
    check("busy_k20", k, 19'd10416);
    cfg_we = 1'b1; cfg_wdata = cfg(1'b0, 1'b1, 1'b1, 19'd2604);
    tick();
    cfg_we = 1'b0;
    repeat (3) tick();
    check("busy_k2", k, 19'd10416);
    check("busy_pend2", cfg_pend, 1);
    check("busy_pen", p_en, 0);
    rx_busy = 1'b0;
    tick();
    check("commit_k", k, 19'd2604);
    check("commit_pen", p_en, 1);
    check("commit_pend", cfg_pend, 0);

    // Minimum latency when idle: two edges; 7-bit mode masks bit7
    cfg_we = 1'b1; cfg_wdata = cfg(1'b1, 1'b0, 1'b0, 19'd100);
    tick();
    cfg_we = 1'b0;
    check("lat1_pend", cfg_pend, 1);
    check("lat1_k", k, 19'd2604);
    tick();
    check("lat2_k", k, 19'd100);
    check("lat2_eight", eight, 0);
    check("lat2_even", even, 1);
    check("lat2_pen", p_en, 0);
    push(8'hC3, 1'b0, 1'b0);
    check("mask7_data", data_out, 8'h43);
    pop();
    check("mask7_empty", rx_rdy, 0);
    cfg_we = 1'b1; cfg_wdata = cfg(1'b0, 1'b1, 1'b1, 19'd2604);
    tick();
    cfg_we = 1'b0;
    tick();
    check("restore_eight", eight, 1);

    // Two frames, second with parity error
    push(8'h41, 1'b0, 1'b0);
    check("p1_rdy", rx_rdy, 1);
    check("p1_data", data_out, 8'h41);
    push(8'h42, 1'b1, 1'b0);
    check("p2_data", data_out, 8'h41);
    check("p2_perr", parity_err, 0);
    check("p2_irq", irq, 1);
    pop();
    check("r1_data", data_out, 8'h42);
    check("r1_perr", parity_err, 1);
    pop();
    check("r2_rdy", rx_rdy, 0);
    check("r2_data", data_out, 0);
    check("r2_perr", parity_err, 0);
    check("r2_irq_lag", irq, 1);
    tick();
    check("r2_irq_clr", irq, 0);

    // Overflow: fifth frame dropped
    push(8'h10, 1'b0, 1'b0);
    push(8'h11, 1'b0, 1'b0);
    push(8'h12, 1'b0, 1'b1);
    push(8'h13, 1'b0, 1'b0);
    check("of_before", overflow, 0);
    push(8'h14, 1'b0, 1'b0);
    check("of_set", overflow, 1);
    check("of_head", data_out, 8'h10);
    tick();
    check("of_irq", irq, 1);
    pop();
    check("of_clr", overflow, 0);
    check("of_h1", data_out, 8'h11);
    pop();
    check("of_h2", data_out, 8'h12);
    check("of_ferr", frame_err, 1);
    pop();
    check("of_h3", data_out, 8'h13);
    check("of_ferr3", frame_err, 0);
    pop();
    check("of_empty", rx_rdy, 0);

    // Full with simultaneous push and pop, wrapping pointers
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rx_done = 1'b1; rx_data = 8'h24 + 8'(i); reads = 1'b1;
      tick();
      rx_done = 1'b0; reads = 1'b0;
      check($sformatf("fp_head%0d", i), data_out, 8'h21 + 8'(i));
      check($sformatf("fp_of%0d", i), overflow, 0);
    end
    push(8'h99, 1'b0, 1'b0);
    check("fp_still_full", overflow, 1);
    check("fp_head_keep", data_out, 8'h28);
    pop();
    check("fp_d1", data_out, 8'h29);
    check("fp_ofclr", overflow, 0);
    pop();
    check("fp_d2", data_out, 8'h2A);
    pop();
    check("fp_d3", data_out, 8'h2B);
    pop();
    check("fp_empty", rx_rdy, 0);

    // Read on empty does nothing; push+pop on empty keeps the push
    pop();
    check("re_empty", rx_rdy, 0);
    rx_done = 1'b1; rx_data = 8'h55; reads = 1'b1;
    tick();
    rx_done = 1'b0; reads = 1'b0;
    check("pe_rdy", rx_rdy, 1);
    check("pe_data", data_out, 8'h55);
    pop();
    check("pe_drain", rx_rdy, 0);

    // Asynchronous reset mid-stream with entries and a pending config
    push(8'h61, 1'b1, 1'b0);
    push(8'h62, 1'b0, 1'b0);
    push(8'h63, 1'b0, 1'b0);
    rx_busy = 1'b1;
    cfg_we = 1'b1; cfg_wdata = cfg(1'b1, 1'b1, 1'b0, 19'd777);
    tick();
    cfg_we = 1'b0;
    check("pre_rst_pend", cfg_pend, 1);
    check("pre_rst_irq", irq, 1);
    #2 rst = 1'b0;
    #1;
    check("ar_k", k, 19'd10416);
    check("ar_eight", eight, 1);
    check("ar_pen", p_en, 0);
    check("ar_pend", cfg_pend, 0);
    check("ar_rdy", rx_rdy, 0);
    check("ar_data", data_out, 0);
    check("ar_perr", parity_err, 0);
    check("ar_irq", irq, 0);
    check("ar_of", overflow, 0);
    rx_busy = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    check("post_rst_k", k, 19'd10416);
    check("post_rst_rdy", rx_rdy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_ctrl_sched.md
Name: rx_ctrl_sched

Overview:
- Control/scheduling block wrapped around the Rx engine.
- Owns the Rx configuration: baud count k, eight, p_en, even. Host writes are staged, then committed only when the Rx engine is idle, so a frame in flight never sees a config change.
- Buffers completed frames from the Rx datapath in a small FIFO with per-byte error flags.
- Generates rx_rdy, overflow and irq toward the host/TSI side.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, log2(DEPTH).
- DEFAULT_K, 19'd10416, reset bit-time count (100 MHz / 9600 baud).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  single-cycle config write strobe.
- cfg_wdata  in  22  config word: [18:0] k, [19] eight, [20] p_en, [21] even.
- rx_busy  in  1  high from start-bit detect until done; config commits are blocked while high.
- rx_done  in  1  one-cycle frame-complete pulse from the Rx datapath.
- rx_data  in  8  received byte; valid with rx_done. When eight=0, bit7 is forced 0 on push.
- rx_perr  in  1  parity error for the frame; valid with rx_done.
- rx_ferr  in  1  framing error for the frame; valid with rx_done.
- reads  in  1  one-cycle host read/pop strobe.
- k  out  19  active bit-time count.
- eight  out  1  active 8-bit mode.
- p_en  out  1  active parity enable.
- even  out  1  active parity sense.
- cfg_pend  out  1  staged config not yet committed.
- data_out  out  8  FIFO head byte.
- parity_err  out  1  head entry's parity flag.
- frame_err  out  1  head entry's frame flag.
- rx_rdy  out  1  FIFO not empty.
- overflow  out  1  sticky: a frame was dropped.
- irq  out  1  registered (rx_rdy | overflow).

Behaviour:
Reset values (asserted low, asynchronous):
- k=DEFAULT_K, eight=1, p_en=0, even=0, cfg_pend=0.
- FIFO empty, rd/wr pointers 0, data_out=0, parity_err=0, frame_err=0, rx_rdy=0, overflow=0, irq=0.
- Reset mid-frame discards FIFO contents and any staged config.

Config FSM, states CFG_IDLE and CFG_PEND:
- CFG_IDLE + cfg_we: staging reg <= cfg_wdata, go to CFG_PEND.
- CFG_PEND + cfg_we: staging reg overwritten (last write wins), stay in CFG_PEND. cfg_we has priority over commit in the same cycle.
- CFG_PEND, rx_busy=0, no cfg_we: active k/eight/p_en/even <= staging, go to CFG_IDLE.
- Minimum write-to-active latency is 2 edges.
- cfg_pend = (state==CFG_PEND).
- While rx_busy=1, active outputs are held indefinitely.

FIFO:
- Push on rx_done; pop on reads when not empty. Entry = {ferr, perr, data[7:0]}.
- Pointer width AW+1; full/empty derived from the MSB compare. Pointers wrap modulo DEPTH.
- Outputs are combinational from the head entry and are 0 when empty.
- Push when full and no pop: frame dropped, overflow<=1, FIFO unchanged.
- Push when full with simultaneous pop: both occur, no overflow.
- Push when empty with simultaneous pop: pop ignored, push occurs.
- reads when empty: no pointer change.
- overflow clears on any reads pulse; if a drop happens in the same cycle, set wins.
- irq is registered: 1-cycle lag from rx_rdy/overflow.
- rx_rdy rises the edge after rx_done (1-cycle latency).

Test Plan:
- Reset, then idle -> k=10416, eight=1, p_en=0, even=0, rx_rdy=0, irq=0.
- cfg_we with k=5208, p_en=1 while rx_busy=1 for 20 cycles, then second cfg_we k=2604 during busy -> k stays 10416 and cfg_pend=1. One edge after rx_busy falls: k=2604, p_en=1, cfg_pend=0.
- Push 0x41, 0x42 (second with rx_perr=1) -> rx_rdy=1, data_out=0x41, parity_err=0. After one reads: data_out=0x42, parity_err=1. After second reads: rx_rdy=0, data_out=0.
- Push 5 frames into DEPTH=4 without reads -> 5th dropped, overflow=1, irq=1. Four reads return frames 1-4 in order; overflow clears on the first read.
- FIFO full, rx_done and reads in the same cycle -> count stays 4, head advances, overflow stays 0. Repeat 8 times to exercise pointer wrap.
- Assert rst low mid-stream with 3 entries and a pending config -> all outputs return to reset values immediately, without waiting for a clock edge.
